// File: rtl/svpwm_vector_sequencer.sv
// Space-vector PWM sequencer: each period maps a latched sector and two dwell
// times onto a registered {U,V,W} switch pattern (edge- or center-aligned).
module svpwm_vector_sequencer #(
  parameter int CNT_W  = 16,
  parameter int PERIOD = 20000,
  parameter int CENTER = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [2:0]       SECTOR,
  input  logic [CNT_W-1:0] T_A,
  input  logic [CNT_W-1:0] T_B,
  output logic [2:0]       PHASE,
  output logic             PERIOD_STB,
  output logic             SAT,
  output logic             SECTOR_ERR
);
  localparam int W1 = CNT_W + 1;
  localparam logic [W1-1:0]    PER_X = W1'(PERIOD);
  localparam logic [CNT_W-1:0] PER   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             load;

  logic [2:0]       sector_reg;
  logic [CNT_W-1:0] ta_reg, tb_reg;
  logic             sat_reg, err_reg;
  logic [CNT_W-1:0] ta_next, tb_next;
  logic             sat_next, err_next;
  logic [W1-1:0]    dwell_sum;

  logic [2:0]       va, vb, seg_vec, phase_next;

  function automatic logic [2:0] vec_of(input logic [2:0] k);
    case (k)
      3'd1:    return 3'b100;
      3'd2:    return 3'b110;
      3'd3:    return 3'b010;
      3'd4:    return 3'b011;
      3'd5:    return 3'b001;
      3'd6:    return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  // EN only matters when a new period could begin
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        count_next = '0;
        if (EN) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (count_reg == LAST) begin
          count_next = '0;
          if (EN) load = 1'b1;
          else    state_next = IDLE;
        end else begin
          count_next = count_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dwell_sum = {1'b0, T_A} + {1'b0, T_B};
    ta_next   = T_A;
    tb_next   = T_B;
    sat_next  = 1'b0;
    if ({1'b0, T_A} >= PER_X) begin
      ta_next  = PER;
      tb_next  = '0;
      sat_next = 1'b1;
    end else if (dwell_sum > PER_X) begin
      tb_next  = PER - T_A;
      sat_next = 1'b1;
    end
    err_next = (SECTOR == 3'd0) || (SECTOR == 3'd7);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sector_reg <= '0;
      ta_reg     <= '0;
      tb_reg     <= '0;
      sat_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else if (load) begin
      sector_reg <= SECTOR;
      ta_reg     <= ta_next;
      tb_reg     <= tb_next;
      sat_reg    <= sat_next;
      err_reg    <= err_next;
    end
  end

  assign va = vec_of(sector_reg);
  assign vb = vec_of((sector_reg == 3'd6) ? 3'd1 : sector_reg + 3'd1);

  generate
    if (CENTER != 0) begin : g_center
      localparam logic [CNT_W-1:0] HALF = CNT_W'(PERIOD / 2);
      logic [CNT_W-1:0] h, qa, qb, z;
      // Halved dwells keep the two half-periods exact mirror images
      always_comb begin
        seg_vec = 3'b000;
        h  = (count_reg < HALF) ? count_reg : LAST - count_reg;
        qa = ta_reg >> 1;
        qb = tb_reg >> 1;
        z  = (HALF - qa - qb) >> 1;
        if (h < z)                seg_vec = 3'b000;
        else if (h < z + qa)      seg_vec = va;
        else if (h < z + qa + qb) seg_vec = vb;
        else                      seg_vec = 3'b111;
      end
    end else begin : g_edge
      logic [W1-1:0] c, t_ab;
      always_comb begin
        seg_vec = 3'b000;
        c       = {1'b0, count_reg};
        t_ab    = {1'b0, ta_reg} + {1'b0, tb_reg};
        if (c < {1'b0, ta_reg}) seg_vec = va;
        else if (c < t_ab)      seg_vec = vb;
        else                    seg_vec = 3'b000;
      end
    end
  endgenerate

  assign phase_next = (state_reg == RUN && !err_reg) ? seg_vec : 3'b000;

  // Flags are delayed alongside PHASE so they line up with the period they describe
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PHASE      <= 3'b000;
      PERIOD_STB <= 1'b0;
      SAT        <= 1'b0;
      SECTOR_ERR <= 1'b0;
    end else begin
      PHASE      <= phase_next;
      PERIOD_STB <= (state_reg == RUN) && (count_reg == '0);
      SAT        <= (state_reg == RUN) && sat_reg;
      SECTOR_ERR <= (state_reg == RUN) && err_reg;
    end
  end
endmodule

// File: tb/tb_svpwm_vector_sequencer.sv
// Directed bench: an edge-aligned and a center-aligned instance share stimulus
// and are compared period by period against hand-computed PHASE patterns.
module tb_svpwm_vector_sequencer;
  localparam int CNT_W  = 8;
  localparam int PERIOD = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic [2:0] sector = 3'd0;
  logic [CNT_W-1:0] t_a = '0;
  logic [CNT_W-1:0] t_b = '0;

  logic [2:0] phase_e, phase_c;
  logic stb_e, stb_c, sat_e, sat_c, err_e, err_c;

  int checks = 0;
  int errors = 0;
  int n;

  logic [2:0] cap_pe [PERIOD];
  logic [2:0] cap_pc [PERIOD];
  logic [2:0] exp_e  [PERIOD];
  logic [2:0] exp_c  [PERIOD];
  logic cap_se [PERIOD];
  logic cap_sc [PERIOD];
  logic cap_sat_e [PERIOD];
  logic cap_sat_c [PERIOD];
  logic cap_err_e [PERIOD];
  logic cap_err_c [PERIOD];

  always #5 clk = ~clk;

  svpwm_vector_sequencer #(.CNT_W(CNT_W), .PERIOD(PERIOD), .CENTER(0)) dut_e (
    .CLK(clk), .RST(rst), .EN(en), .SECTOR(sector), .T_A(t_a), .T_B(t_b),
    .PHASE(phase_e), .PERIOD_STB(stb_e), .SAT(sat_e), .SECTOR_ERR(err_e)
  );

  svpwm_vector_sequencer #(.CNT_W(CNT_W), .PERIOD(PERIOD), .CENTER(1)) dut_c (
    .CLK(clk), .RST(rst), .EN(en), .SECTOR(sector), .T_A(t_a), .T_B(t_b),
    .PHASE(phase_c), .PERIOD_STB(stb_c), .SAT(sat_c), .SECTOR_ERR(err_c)
  );

  task automatic fill_e(input int s, input int cnt, input logic [2:0] v);
    for (int i = s; i < s + cnt; i++) exp_e[i] = v;
  endtask

  task automatic fill_c(input int s, input int cnt, input logic [2:0] v);
    for (int i = s; i < s + cnt; i++) exp_c[i] = v;
  endtask

  // Records one period starting at the current negedge (sample 0) and can
  // change inputs after sampling index data_idx / en_idx.
  task automatic capture(input int data_idx, input logic [2:0] nsec,
                         input logic [CNT_W-1:0] nta, input logic [CNT_W-1:0] ntb,
                         input int en_idx, input logic nen);
    for (int i = 0; i < PERIOD; i++) begin
      if (i > 0) @(negedge clk);
      cap_pe[i] = phase_e;    cap_pc[i] = phase_c;
      cap_se[i] = stb_e;      cap_sc[i] = stb_c;
      cap_sat_e[i] = sat_e;   cap_sat_c[i] = sat_c;
      cap_err_e[i] = err_e;   cap_err_c[i] = err_c;
      if (i == data_idx) begin
        sector = nsec; t_a = nta; t_b = ntb;
      end
      if (i == en_idx) en = nen;
    end
  endtask

  task automatic wait_stb(input string name, output int cyc);
    cyc = 0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(negedge clk);
      if (stb_e === 1'b1) cyc = i;
    end
    checks++;
    if (cyc == 0) begin
      errors++;
      $display("FAIL %s stb_wait: no PERIOD_STB within 40 cycles", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({phase_e, phase_c} !== 6'b0) begin
      errors++; $display("FAIL reset phase got %b/%b want 000/000", phase_e, phase_c);
    end
    checks++;
    if ({stb_e, sat_e, err_e, stb_c, sat_c, err_c} !== 6'b0) begin
      errors++; $display("FAIL reset flags got %b%b%b%b%b%b want 000000",
                         stb_e, sat_e, err_e, stb_c, sat_c, err_c);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (phase_e !== 3'b000 || stb_e !== 1'b0) begin
        errors++; $display("FAIL reset idle[%0d] phase %b stb %b want 000 0", i, phase_e, stb_e);
      end
    end
    $display("reset: done");
  endtask

  task automatic test_edge_basic;
    sector = 3'd1; t_a = 8'd5; t_b = 8'd3; en = 1'b1;
    wait_stb("edge_basic", n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL edge_basic start_latency got %0d want 2", n);
    end
    capture(-1, 3'd1, 8'd5, 8'd3, -1, 1'b1);
    fill_e(0, 5, 3'b100); fill_e(5, 3, 3'b110); fill_e(8, 12, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_se[i] !== (i == 0) || cap_sat_e[i] !== 1'b0) begin
        errors++;
        $display("FAIL edge_basic [%0d] phase %b stb %b sat %b want %b %b 0",
                 i, cap_pe[i], cap_se[i], cap_sat_e[i], exp_e[i], (i == 0));
      end
    end
    @(negedge clk);
    checks++;
    if (stb_e !== 1'b1) begin
      errors++; $display("FAIL edge_basic stb_period got %b want 1", stb_e);
    end
    $display("edge_basic: sector 1 ta 5 tb 3 checked");
  endtask

  task automatic test_center;
    sector = 3'd2; t_a = 8'd6; t_b = 8'd4;
    repeat (PERIOD) @(negedge clk);
    capture(-1, 3'd2, 8'd6, 8'd4, -1, 1'b1);
    fill_c(0, 2, 3'b000); fill_c(2, 3, 3'b110); fill_c(5, 2, 3'b010); fill_c(7, 6, 3'b111);
    fill_c(13, 2, 3'b010); fill_c(15, 3, 3'b110); fill_c(18, 2, 3'b000);
    fill_e(0, 6, 3'b110); fill_e(6, 4, 3'b010); fill_e(10, 10, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pc[i] !== exp_c[i] || cap_sc[i] !== (i == 0) || cap_sat_c[i] !== 1'b0) begin
        errors++;
        $display("FAIL center [%0d] phase %b stb %b sat %b want %b %b 0",
                 i, cap_pc[i], cap_sc[i], cap_sat_c[i], exp_c[i], (i == 0));
      end
      checks++;
      if (cap_pe[i] !== exp_e[i]) begin
        errors++; $display("FAIL center_edge_inst [%0d] phase %b want %b", i, cap_pe[i], exp_e[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (stb_c !== 1'b1) begin
      errors++; $display("FAIL center stb_period got %b want 1", stb_c);
    end
    $display("center: sector 2 ta 6 tb 4 checked");
  endtask

  task automatic test_saturation;
    sector = 3'd1; t_a = 8'd15; t_b = 8'd10;
    repeat (PERIOD) @(negedge clk);
    // sum overflow: tb clamped to PERIOD - T_A
    capture(5, 3'd1, 8'd25, 8'd3, -1, 1'b1);
    fill_e(0, 15, 3'b100); fill_e(15, 5, 3'b110);
    fill_c(0, 7, 3'b100); fill_c(7, 2, 3'b110); fill_c(9, 2, 3'b111);
    fill_c(11, 2, 3'b110); fill_c(13, 7, 3'b100);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_pc[i] !== exp_c[i] ||
          cap_sat_e[i] !== 1'b1 || cap_sat_c[i] !== 1'b1) begin
        errors++;
        $display("FAIL sat_sum [%0d] phase %b/%b sat %b/%b want %b/%b 1/1",
                 i, cap_pe[i], cap_pc[i], cap_sat_e[i], cap_sat_c[i], exp_e[i], exp_c[i]);
      end
    end
    @(negedge clk);
    // T_A beyond PERIOD: whole period on VA
    capture(5, 3'd1, 8'd12, 8'd8, -1, 1'b1);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== 3'b100 || cap_pc[i] !== 3'b100 ||
          cap_sat_e[i] !== 1'b1 || cap_sat_c[i] !== 1'b1 || cap_se[i] !== (i == 0)) begin
        errors++;
        $display("FAIL sat_ta [%0d] phase %b/%b sat %b/%b stb %b want 100/100 1/1 %b",
                 i, cap_pe[i], cap_pc[i], cap_sat_e[i], cap_sat_c[i], cap_se[i], (i == 0));
      end
    end
    @(negedge clk);
    // exactly PERIOD total: no clamp
    capture(5, 3'd1, 8'd2, 8'd2, -1, 1'b1);
    fill_e(0, 12, 3'b100); fill_e(12, 8, 3'b110);
    fill_c(0, 6, 3'b100); fill_c(6, 8, 3'b110); fill_c(14, 6, 3'b100);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_pc[i] !== exp_c[i] ||
          cap_sat_e[i] !== 1'b0 || cap_sat_c[i] !== 1'b0) begin
        errors++;
        $display("FAIL sat_exact [%0d] phase %b/%b sat %b/%b want %b/%b 0/0",
                 i, cap_pe[i], cap_pc[i], cap_sat_e[i], cap_sat_c[i], exp_e[i], exp_c[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (stb_e !== 1'b1 || sat_e !== 1'b0 || phase_e !== 3'b100) begin
      errors++;
      $display("FAIL sat_clear stb %b sat %b phase %b want 1 0 100", stb_e, sat_e, phase_e);
    end
    $display("saturation: sum clamp, ta clamp, exact fit, clear checked");
  endtask

  task automatic test_sector_err;
    sector = 3'd7; t_a = 8'd5; t_b = 8'd3;
    repeat (PERIOD) @(negedge clk);
    capture(4, 3'd3, 8'd5, 8'd3, -1, 1'b1);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== 3'b000 || cap_pc[i] !== 3'b000 ||
          cap_err_e[i] !== 1'b1 || cap_err_c[i] !== 1'b1) begin
        errors++;
        $display("FAIL sector7 [%0d] phase %b/%b err %b/%b want 000/000 1/1",
                 i, cap_pe[i], cap_pc[i], cap_err_e[i], cap_err_c[i]);
      end
    end
    @(negedge clk);
    capture(-1, 3'd3, 8'd5, 8'd3, -1, 1'b1);
    fill_e(0, 5, 3'b010); fill_e(5, 3, 3'b011); fill_e(8, 12, 3'b000);
    fill_c(0, 3, 3'b000); fill_c(3, 2, 3'b010); fill_c(5, 1, 3'b011); fill_c(6, 8, 3'b111);
    fill_c(14, 1, 3'b011); fill_c(15, 2, 3'b010); fill_c(17, 3, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_pc[i] !== exp_c[i] || cap_err_e[i] !== 1'b0) begin
        errors++;
        $display("FAIL sector3 [%0d] phase %b/%b err %b want %b/%b 0",
                 i, cap_pe[i], cap_pc[i], cap_err_e[i], exp_e[i], exp_c[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (stb_e !== 1'b1) begin
      errors++; $display("FAIL sector3 stb_period got %b want 1", stb_e);
    end
    $display("sector_err: sector 7 then 3 checked");
  endtask

  task automatic test_double_buffer;
    sector = 3'd1; t_a = 8'd5; t_b = 8'd3;
    repeat (PERIOD) @(negedge clk);
    capture(6, 3'd1, 8'd9, 8'd3, 9, 1'b0);
    fill_e(0, 5, 3'b100); fill_e(5, 3, 3'b110); fill_e(8, 12, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i]) begin
        errors++; $display("FAIL dbuf_old [%0d] phase %b want %b", i, cap_pe[i], exp_e[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (phase_e !== 3'b000 || phase_c !== 3'b000 || stb_e !== 1'b0 || stb_c !== 1'b0) begin
        errors++;
        $display("FAIL dbuf_idle [%0d] phase %b/%b stb %b/%b want 000/000 0/0",
                 i, phase_e, phase_c, stb_e, stb_c);
      end
    end
    en = 1'b1;
    wait_stb("dbuf_restart", n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL dbuf_restart latency got %0d want 2", n);
    end
    capture(5, 3'd1, 8'd15, 8'd10, -1, 1'b1);
    fill_e(0, 9, 3'b100); fill_e(9, 3, 3'b110); fill_e(12, 8, 3'b000);
    fill_c(0, 2, 3'b000); fill_c(2, 4, 3'b100); fill_c(6, 1, 3'b110); fill_c(7, 6, 3'b111);
    fill_c(13, 1, 3'b110); fill_c(14, 4, 3'b100); fill_c(18, 2, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_pc[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL dbuf_new [%0d] phase %b/%b want %b/%b",
                 i, cap_pe[i], cap_pc[i], exp_e[i], exp_c[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (stb_e !== 1'b1) begin
      errors++; $display("FAIL dbuf_new stb_period got %b want 1", stb_e);
    end
    $display("double_buffer: old values kept, idle, restart with new values checked");
  endtask

  task automatic test_async_reset;
    repeat (8) @(negedge clk);
    checks++;
    if (phase_e !== 3'b100 || phase_c !== 3'b110 || sat_e !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre phase %b/%b sat %b want 100/110 1", phase_e, phase_c, sat_e);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({phase_e, phase_c, stb_e, stb_c, sat_e, sat_c, err_e, err_c} !== 12'b0) begin
      errors++;
      $display("FAIL areset_now phase %b/%b stb %b/%b sat %b/%b err %b/%b want all 0",
               phase_e, phase_c, stb_e, stb_c, sat_e, sat_c, err_e, err_c);
    end
    sector = 3'd1; t_a = 8'd5; t_b = 8'd3; en = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (phase_e !== 3'b000 || stb_e !== 1'b0) begin
      errors++; $display("FAIL areset_hold phase %b stb %b want 000 0", phase_e, stb_e);
    end
    rst = 1'b0;
    wait_stb("areset_restart", n);
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL areset_restart latency got %0d want 2", n);
    end
    capture(-1, 3'd1, 8'd5, 8'd3, -1, 1'b1);
    fill_e(0, 5, 3'b100); fill_e(5, 3, 3'b110); fill_e(8, 12, 3'b000);
    for (int i = 0; i < PERIOD; i++) begin
      checks++;
      if (cap_pe[i] !== exp_e[i] || cap_sat_e[i] !== 1'b0 || cap_se[i] !== (i == 0)) begin
        errors++;
        $display("FAIL areset_period [%0d] phase %b sat %b stb %b want %b 0 %b",
                 i, cap_pe[i], cap_sat_e[i], cap_se[i], exp_e[i], (i == 0));
      end
    end
    $display("async_reset: mid-period reset and restart checked");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_edge_basic();
    test_center();
    test_saturation();
    test_sector_err();
    test_double_buffer();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
